// File: rtl/inert_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inert_seq : inertial sensor SPI sequencer (power-up, init, reads).   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module inert_seq #(
  parameter int PWRUP_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld,
  output logic        init_cmplt
);

  typedef enum logic [2:0] {
    S_PWRUP    = 3'd0,
    S_INIT     = 3'd1,
    S_WAIT_INT = 3'd2,
    S_READ     = 3'd3,
    S_VLD      = 3'd4
  } state_t;

  localparam logic [PWRUP_W-1:0] C_TMR_ONE = {{(PWRUP_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [PWRUP_W-1:0] tmr_q, tmr_d;
  logic [1:0]         idx_q, idx_d;
  logic               pend_q, pend_d;
  logic               int_s1_q, int_s2_q;
  logic [7:0]         p_lo_q, p_lo_d, p_hi_q, p_hi_d;
  logic [7:0]         a_lo_q, a_lo_d, a_hi_q, a_hi_d;
  logic [15:0]        ptch_q, ptch_d, az_q, az_d;
  logic               init_q, init_d;
  logic               unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:8];

  function automatic logic [15:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 16'h0D02;
      2'd1:    init_cmd = 16'h1053;
      2'd2:    init_cmd = 16'h1150;
      default: init_cmd = 16'h1460;
    endcase
  endfunction

  function automatic logic [7:0] read_addr(input logic [1:0] i);
    case (i)
      2'd0:    read_addr = 8'hA2;
      2'd1:    read_addr = 8'hA3;
      2'd2:    read_addr = 8'hAC;
      default: read_addr = 8'hAD;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    p_lo_d  = p_lo_q;
    p_hi_d  = p_hi_q;
    a_lo_d  = a_lo_q;
    a_hi_d  = a_hi_q;
    ptch_d  = ptch_q;
    az_d    = az_q;
    init_d  = init_q;
    wrt     = 1'b0;
    vld     = 1'b0;
    cmd     = 16'h0000;
    case (state_q)
      S_PWRUP: begin
        tmr_d = tmr_q + C_TMR_ONE;
        if (&tmr_q) begin
          tmr_d   = '0;
          idx_d   = 2'd0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        cmd = init_cmd(idx_q);
        // Issue cycle ignores done: the master is still clearing the old level.
        if (!pend_q) begin
          wrt    = 1'b1;
          pend_d = 1'b1;
        end else if (done) begin
          pend_d = 1'b0;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            init_d  = 1'b1;
            state_d = S_WAIT_INT;
          end
        end
      end
      S_WAIT_INT: begin
        if (int_s2_q) begin
          idx_d   = 2'd0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        cmd = {read_addr(idx_q), 8'h00};
        if (!pend_q) begin
          wrt    = 1'b1;
          pend_d = 1'b1;
        end else if (done) begin
          pend_d = 1'b0;
          idx_d  = idx_q + 2'd1;
          case (idx_q)
            2'd0:    p_lo_d = rd_data[7:0];
            2'd1:    p_hi_d = rd_data[7:0];
            2'd2:    a_lo_d = rd_data[7:0];
            default: a_hi_d = rd_data[7:0];
          endcase
          if (idx_q == 2'd3) state_d = S_VLD;
        end
      end
      S_VLD: begin
        vld     = 1'b1;
        ptch_d  = {p_hi_q, p_lo_q};
        az_d    = {a_hi_q, a_lo_q};
        state_d = S_WAIT_INT;
      end
      default: state_d = S_PWRUP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_PWRUP;
      tmr_q    <= '0;
      idx_q    <= 2'd0;
      pend_q   <= 1'b0;
      int_s1_q <= 1'b0;
      int_s2_q <= 1'b0;
      p_lo_q   <= 8'h00;
      p_hi_q   <= 8'h00;
      a_lo_q   <= 8'h00;
      a_hi_q   <= 8'h00;
      ptch_q   <= 16'h0000;
      az_q     <= 16'h0000;
      init_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      int_s1_q <= INT;
      int_s2_q <= int_s1_q;
      p_lo_q   <= p_lo_d;
      p_hi_q   <= p_hi_d;
      a_lo_q   <= a_lo_d;
      a_hi_q   <= a_hi_d;
      ptch_q   <= ptch_d;
      az_q     <= az_d;
      init_q   <= init_d;
    end
  end

  assign ptch_rt    = ptch_q;
  assign AZ         = az_q;
  assign init_cmplt = init_q;

endmodule
`default_nettype wire

// File: tb/tb_inert_seq.sv
`default_nettype none
`timescale 1ns/1ps
// Testbench for inert_seq: SPI slave model, command-order and handshake
// monitors, and a scoreboard of assembled sensor words.
module tb_inert_seq;
  localparam int PW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt, vld, init_cmplt;
  logic [15:0] cmd, ptch_rt, AZ;

  int          checks = 0;
  int          failures = 0;
  longint      cyc = 0;
  int          tspi = 40;
  int          vld_cnt = 0;
  int          wrt_cnt = 0;
  logic [7:0]  sens [4];
  logic [31:0] exp_q [$];
  longint      vld_cyc [$];

  inert_seq #(.PWRUP_W(PW)) dut (
    .clk(clk), .rst(rst), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .ptch_rt(ptch_rt), .AZ(AZ), .vld(vld),
    .init_cmplt(init_cmplt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sel_of(input logic [15:0] c);
    case (c[15:8])
      8'hA2:   return 0;
      8'hA3:   return 1;
      8'hAC:   return 2;
      8'hAD:   return 3;
      default: return 0;
    endcase
  endfunction

  // SPI master model: done cleared on the edge that samples wrt,
  // then raised so that it is seen on the tspi-th wait clock.
  int          s_cnt = 0;
  int          s_sel = 0;
  always @(posedge clk) begin
    if (rst) begin
      s_cnt <= 0;
      done  <= 1'b0;
    end else if (wrt) begin
      done    <= 1'b0;
      s_cnt   <= tspi - 1;
      s_sel   <= sel_of(cmd);
      rd_data <= 16'($urandom);
    end else if (s_cnt > 0) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1) begin
        done    <= 1'b1;
        rd_data <= {8'($urandom), sens[s_sel]};
      end
    end
  end

  // Command order and handshake monitor.
  initial begin : cmd_mon
    logic [15:0] exp_cmds [8];
    int          pos;
    logic        pend, prev_wrt, bad_hold;
    logic [15:0] hold;
    exp_cmds = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460,
                 16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
    pos = 0; pend = 1'b0; prev_wrt = 1'b0; bad_hold = 1'b0; hold = 16'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pos = 0; pend = 1'b0; prev_wrt = 1'b0; bad_hold = 1'b0;
      end else begin
        if (wrt) begin
          checks++;
          if (prev_wrt || pend) begin
            failures++;
            $display("FAIL wrt_handshake prev_wrt=%0b pending=%0b required 0/0", prev_wrt, pend);
          end
          checks++;
          if (cmd !== exp_cmds[pos]) begin
            failures++;
            $display("FAIL cmd_order got=%h required=%h", cmd, exp_cmds[pos]);
          end
          pos = (pos == 7) ? 4 : pos + 1;
          pend = 1'b1; hold = cmd; bad_hold = 1'b0;
          wrt_cnt++;
        end else if (pend) begin
          if (cmd !== hold) bad_hold = 1'b1;
          if (done) begin
            pend = 1'b0;
            checks++;
            if (bad_hold) begin
              failures++;
              $display("FAIL cmd_hold last=%h required=%h", cmd, hold);
            end
          end
        end
        prev_wrt = wrt;
      end
    end
  end

  // Output monitor: scoreboard pop on the cycle after vld, stability otherwise.
  initial begin : out_mon
    logic        vprev;
    logic [15:0] lp, la;
    logic [31:0] e;
    vprev = 1'b0; lp = 16'h0; la = 16'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        vprev = 1'b0; lp = 16'h0; la = 16'h0;
      end else begin
        checks++;
        if (vprev) begin
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_vld ptch_rt=%h AZ=%h required no vld", ptch_rt, AZ);
          end else begin
            e = exp_q.pop_front();
            if ({ptch_rt, AZ} !== e) begin
              failures++;
              $display("FAIL sample ptch_rt=%h AZ=%h required %h %h", ptch_rt, AZ, e[31:16], e[15:0]);
            end
          end
        end else if (ptch_rt !== lp || AZ !== la) begin
          failures++;
          $display("FAIL output_stable ptch_rt=%h AZ=%h required %h %h", ptch_rt, AZ, lp, la);
        end
        if (vld) begin
          vld_cnt++;
          vld_cyc.push_back(cyc);
          checks++;
          if (vprev) begin
            failures++;
            $display("FAIL vld_width vld high 2 clks required 1");
          end
        end
        vprev = vld; lp = ptch_rt; la = AZ;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({wrt, cmd, ptch_rt, AZ, vld, init_cmplt} !== 51'd0) begin
      failures++;
      $display("FAIL %s wrt=%b cmd=%h ptch_rt=%h AZ=%h vld=%b init=%b required all 0",
               nm, wrt, cmd, ptch_rt, AZ, vld, init_cmplt);
    end
  endtask

  // Releases reset and measures clocks to the first wrt.
  task automatic powerup(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    #1 rst = 1'b0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (wrt) break;
    end
    checks++;
    if (n != (1 << PW) || !wrt) begin
      failures++;
      $display("FAIL %s first_wrt clocks=%0d wrt=%b required %0d", nm, n, wrt, 1 << PW);
    end
    checks++;
    if (cmd !== 16'h0D02) begin
      failures++;
      $display("FAIL %s first_cmd got=%h required 0d02", nm, cmd);
    end
  endtask

  task automatic wait_init(input int bound);
    int n;
    n = 0;
    while (!init_cmplt && n < bound) begin tick(1); n++; end
    checks++;
    if (init_cmplt !== 1'b1) begin
      failures++;
      $display("FAIL init_cmplt got=%b required 1", init_cmplt);
    end
  endtask

  task automatic wait_vld(input int target, input int bound);
    int n;
    n = 0;
    while (vld_cnt < target && n < bound) begin tick(1); n++; end
    if (vld_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL vld_timeout count=%0d required %0d", vld_cnt, target);
    end
  endtask

  task automatic rand_sens();
    for (int i = 0; i < 4; i++) sens[i] = 8'($urandom);
  endtask

  function automatic logic [31:0] expect_word();
    return {sens[1], sens[0], sens[3], sens[2]};
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w0, base, per, k, n;
    tick(2);
    #1 check_zero("reset_outputs");

    // Power-up timing and init order with a slow master.
    tspi = 40;
    powerup("pwrup1");
    wait_init(1000);
    w0 = wrt_cnt;
    tick(50);
    checks++;
    if (wrt_cnt != w0) begin
      failures++;
      $display("FAIL idle_no_wrt wrt_count=%0d required %0d", wrt_cnt, w0);
    end

    // Fixed read; a second INT during READ must not add a sequence.
    sens = '{8'h34, 8'h12, 8'hCD, 8'hAB};
    exp_q.push_back(32'h1234ABCD);
    INT = 1'b1; tick(4); INT = 1'b0;
    tick(12);
    INT = 1'b1; tick(3); INT = 1'b0;
    wait_vld(1, 1000);
    tick(60);
    checks++;
    if (vld_cnt != 1) begin
      failures++;
      $display("FAIL int_during_read vld_count=%0d required 1", vld_cnt);
    end

    // Randomized single reads with a faster master.
    for (int it = 0; it < 6; it++) begin
      tspi = $urandom_range(2, 6);
      rand_sens();
      exp_q.push_back(expect_word());
      INT = 1'b1; tick($urandom_range(3, 5)); INT = 1'b0;
      wait_vld(vld_cnt + 1, 500);
      tick($urandom_range(2, 6));
    end

    // INT held high: back-to-back sequences at the fixed latency.
    tspi = 3;
    k = 3;
    rand_sens();
    base = vld_cnt;
    for (int i = 0; i <= k; i++) exp_q.push_back(expect_word());
    INT = 1'b1;
    wait_vld(base + k, 500);
    tick(10);
    INT = 1'b0;
    wait_vld(base + k + 1, 500);
    per = 2 + 4 * (1 + tspi);
    n = vld_cyc.size();
    for (int i = n - k; i < n; i++) begin
      checks++;
      if (vld_cyc[i] - vld_cyc[i-1] != longint'(per)) begin
        failures++;
        $display("FAIL vld_spacing got=%0d required %0d", vld_cyc[i] - vld_cyc[i-1], per);
      end
    end
    tick(60);
    checks++;
    if (vld_cnt != base + k + 1) begin
      failures++;
      $display("FAIL held_int_stop vld_count=%0d required %0d", vld_cnt, base + k + 1);
    end

    // Reset while waiting for done of the AZ low-byte read.
    tspi = 40;
    rand_sens();
    exp_q.push_back(expect_word());
    INT = 1'b1;
    n = 0;
    while (!(wrt && cmd[15:8] == 8'hAC) && n < 2000) begin tick(1); n++; end
    checks++;
    if (!(wrt && cmd[15:8] == 8'hAC)) begin
      failures++;
      $display("FAIL ac_wait cmd=%h wrt=%b required ac00 issued", cmd, wrt);
    end
    INT = 1'b0;
    tick(5);
    #1 rst = 1'b1;
    #1 check_zero("reset_mid_read");
    exp_q.delete();
    tick(3);
    powerup("pwrup2");
    wait_init(1000);

    // Recovery read after the reset.
    tspi = 4;
    rand_sens();
    exp_q.push_back(expect_word());
    base = vld_cnt;
    INT = 1'b1; tick(4); INT = 1'b0;
    wait_vld(base + 1, 500);
    tick(5);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover entries=%0d required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
